// File: rtl/mem_responder.sv
// Single-port word memory that answers CPU requests after a fixed, parameterised latency.
// One request in flight at a time; operands are captured at acceptance and the result lands on entry to DONE.
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_enable,
  input  logic        read_or_write,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..15");
  end

  // Handshake: the CPU holds mem_enable until mem_ready; a request is accepted
  // at the first edge that sees mem_enable=1 in IDLE, and mem_ready is high for
  // exactly the one DONE cycle that completes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    rw_q, rw_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    mem_we;
  logic [31:0]             mem_q [DEPTH];

  // Byte-offset bits and bits above the array size play no part in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_enable) begin
          idx_d   = addr[DEPTH_LOG2+1:2];
          wdata_d = write_data;
          rw_d    = read_or_write;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (rw_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rw_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
    end
  end

  // The array survives reset; only a commit that coincides with reset is blocked.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign read_data = rdata_q;
  assign mem_ready = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios on a LATENCY=2 instance and a
// randomized sweep on a LATENCY=1 instance checked against an array model.
module tb_mem_responder;

  localparam int LAT_A = 2;
  localparam int DL_A  = 10;
  localparam int LAT_B = 1;
  localparam int DL_B  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic        read_or_write = 1'b0;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;
  logic [31:0] rd_a, rd_b;
  logic        rdy_a, rdy_b;
  logic [1:0]  st_a, st_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_responder #(.DEPTH_LOG2(DL_A), .LATENCY(LAT_A)) dut_a (
    .clock(clock), .reset(reset), .addr(addr), .write_data(write_data),
    .mem_enable(en_a), .read_or_write(read_or_write),
    .read_data(rd_a), .mem_ready(rdy_a), .dbg_state(st_a)
  );

  mem_responder #(.DEPTH_LOG2(DL_B), .LATENCY(LAT_B)) dut_b (
    .clock(clock), .reset(reset), .addr(addr), .write_data(write_data),
    .mem_enable(en_b), .read_or_write(read_or_write),
    .read_data(rd_b), .mem_ready(rdy_b), .dbg_state(st_b)
  );

  // Drives one request to instance sel (0 = A, 1 = B) starting now, and counts
  // rising edges until mem_ready is seen. Called #1 after a rising edge.
  task automatic txn(input int sel, input logic rw, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output logic [31:0] rd);
    addr = a;
    write_data = d;
    read_or_write = rw;
    if (sel == 1) en_b = 1'b1; else en_a = 1'b1;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clock); #1;
      if ((sel == 1 ? rdy_b : rdy_a) === 1'b1) begin
        lat = i;
        break;
      end
    end
    en_a = 1'b0;
    en_b = 1'b0;
    rd = (sel == 1) ? rd_b : rd_a;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL txn_timeout: sel=%0d addr=%h no mem_ready within 50 cycles", sel, a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got a=%b b=%b, expected 0 0", rdy_a, rdy_b);
    end
    checks++;
    if (rd_a !== 32'h0 || rd_b !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got a=%h b=%h, expected 0 0", rd_a, rd_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] rd;
    // Acceptance at the first edge, completion LATENCY edges later.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd);
    checks++;
    if (lat !== LAT_A + 1) begin
      errors++; $display("FAIL wr_latency: got %0d edges, expected %0d", lat, LAT_A + 1);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL wr_keeps_rdata: got %h, expected 00000000", rd);
    end
    @(posedge clock); #1;
    checks++;
    if (rdy_a !== 1'b0) begin
      errors++; $display("FAIL wr_pulse_width: ready still %b one cycle later, expected 0", rdy_a);
    end
    txn(0, 1'b0, 32'h10, 32'h0, lat, rd);
    checks++;
    if (lat !== LAT_A + 1) begin
      errors++; $display("FAIL rd_latency: got %0d edges, expected %0d", lat, LAT_A + 1);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_data: got %h, expected deadbeef", rd);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (rd_a !== 32'hDEADBEEF || rdy_a !== 1'b0) begin
      errors++; $display("FAIL rd_hold: got data=%h ready=%b, expected deadbeef 0", rd_a, rdy_a);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] rd;
    txn(0, 1'b1, 32'h0, 32'h11111111, lat, rd);
    checks++;
    if (lat !== LAT_A + 1) begin
      errors++; $display("FAIL b2b_first_latency: got %0d, expected %0d", lat, LAT_A + 1);
    end
    // Enable stays high: DONE, one IDLE cycle that accepts, then LATENCY edges.
    txn(0, 1'b0, 32'h0, 32'h0, lat, rd);
    checks++;
    if (lat !== LAT_A + 2) begin
      errors++; $display("FAIL b2b_spacing: got %0d edges between pulses, expected %0d", lat, LAT_A + 2);
    end
    checks++;
    if (rd !== 32'h11111111) begin
      errors++; $display("FAIL b2b_data: got %h, expected 11111111", rd);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_aliasing();
    int lat;
    logic [31:0] rd;
    txn(0, 1'b1, 32'h1004, 32'hA5A5A5A5, lat, rd);
    @(posedge clock); #1;
    txn(0, 1'b0, 32'h0006, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL alias_data: got %h, expected a5a5a5a5", rd);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_mid_change();
    int lat;
    logic [31:0] rd;
    bit seen;
    txn(0, 1'b1, 32'h40, 32'h66666666, lat, rd);
    @(posedge clock); #1;
    addr = 32'h20;
    write_data = 32'h77777777;
    read_or_write = 1'b1;
    en_a = 1'b1;
    @(posedge clock); #1;
    // Accepted; scramble the operands and drop enable while BUSY.
    addr = 32'h40;
    write_data = 32'h99999999;
    read_or_write = 1'b0;
    en_a = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (rdy_a === 1'b1) begin
        checks++;
        if (i !== LAT_A) begin
          errors++; $display("FAIL mid_latency: got %0d more edges, expected %0d", i, LAT_A);
        end
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL mid_complete: got no mem_ready, expected completion");
    end
    @(posedge clock); #1;
    txn(0, 1'b0, 32'h20, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'h77777777) begin
      errors++; $display("FAIL mid_orig_addr: got %h, expected 77777777", rd);
    end
    txn(0, 1'b0, 32'h40, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'h66666666) begin
      errors++; $display("FAIL mid_new_addr: got %h, expected 66666666", rd);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_busy();
    int lat;
    logic [31:0] rd;
    bit bad_ready;
    txn(0, 1'b1, 32'h30, 32'h12345678, lat, rd);
    @(posedge clock); #1;
    addr = 32'h30;
    write_data = 32'hCAFEF00D;
    read_or_write = 1'b1;
    en_a = 1'b1;
    @(posedge clock); #1;
    en_a = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    bad_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rdy_a !== 1'b0) bad_ready = 1'b1;
      @(posedge clock); #1;
    end
    checks++;
    if (bad_ready) begin
      errors++; $display("FAIL rst_busy_ready: got a mem_ready pulse, expected none");
    end
    checks++;
    if (rd_a !== 32'h0 || rd_b !== 32'h0) begin
      errors++; $display("FAIL rst_busy_rdata: got a=%h b=%h, expected 0 0", rd_a, rd_b);
    end
    txn(0, 1'b0, 32'h30, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'h12345678) begin
      errors++; $display("FAIL rst_busy_mem: got %h, expected 12345678", rd);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_sweep();
    logic [31:0] model_mem [int];
    logic [31:0] model_rd;
    logic [31:0] a, d, rd;
    logic        rw;
    int          lat, gap, word, exp_lat;
    bit          just_done;
    model_rd = rd_b;
    just_done = 1'b0;
    // Fill every word first so each later read has a defined answer.
    for (int w = 0; w < (1 << DL_B); w++) begin
      d = $urandom;
      txn(1, 1'b1, 32'(w * 4), d, lat, rd);
      model_mem[w] = d;
      @(posedge clock); #1;
    end
    for (int n = 0; n < 250; n++) begin
      rw = 1'($urandom_range(0, 1));
      a = $urandom;
      d = $urandom;
      gap = $urandom_range(0, 2);
      word = int'((a >> 2) % (1 << DL_B));
      exp_lat = LAT_B + 1 + (just_done ? 1 : 0);
      txn(1, rw, a, d, lat, rd);
      checks++;
      if (lat !== exp_lat) begin
        errors++; $display("FAIL sweep_latency[%0d]: got %0d, expected %0d", n, lat, exp_lat);
      end
      if (rw) model_mem[word] = d;
      else model_rd = model_mem[word];
      checks++;
      if (rd !== model_rd) begin
        errors++;
        $display("FAIL sweep_rdata[%0d]: rw=%b addr=%h got %h, expected %h", n, rw, a, rd, model_rd);
      end
      just_done = (gap == 0);
      for (int g = 0; g < gap; g++) begin
        @(posedge clock); #1;
        checks++;
        if (rdy_b !== 1'b0) begin
          errors++; $display("FAIL sweep_pulse[%0d]: ready=%b in idle gap, expected 0", n, rdy_b);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_aliasing();
    test_mid_change();
    test_reset_busy();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
